// File: rtl/regfile_writeback_queue_if.sv
// Writeback bus between the ALU/load producers, the writeback queue and the
// register file write port.
//   master : producer/register-file side (drives requests and read addresses)
//   slave  : writeback queue side (drives readies, write port, count, hazards)
// Parameters: DEPTH (queue entries), AW (register address width), DW (data width).
interface regfile_writeback_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          ALU_VALID;
    logic          ALU_READY;
    logic [AW-1:0] ALU_ADDR;
    logic [DW-1:0] ALU_DATA;
    logic          MEM_VALID;
    logic          MEM_READY;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DATA;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic          WE3;
    logic [CW-1:0] COUNT;
    logic [AW-1:0] RA1;
    logic [AW-1:0] RA2;
    logic          HAZ1;
    logic          HAZ2;

    modport master (
        output ALU_VALID, ALU_ADDR, ALU_DATA,
        output MEM_VALID, MEM_ADDR, MEM_DATA,
        output RA1, RA2,
        input  ALU_READY, MEM_READY,
        input  A3, WD3, WE3, COUNT, HAZ1, HAZ2
    );

    modport slave (
        input  ALU_VALID, ALU_ADDR, ALU_DATA,
        input  MEM_VALID, MEM_ADDR, MEM_DATA,
        input  RA1, RA2,
        output ALU_READY, MEM_READY,
        output A3, WD3, WE3, COUNT, HAZ1, HAZ2
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue feeding the register file's single write port.
// Two producers (ALU result, memory load) enqueue through valid/ready; one
// entry drains per cycle onto A3/WD3/WE3.
// Ports:
//   CLK   : clock, all state on posedge
//   RESET : synchronous active-high reset, flushes the queue
//   bus   : regfile_writeback_queue_if.slave (producer handshakes, write port,
//           COUNT, RA1/RA2 hazard inputs and HAZ1/HAZ2 outputs)
// Optional feature: define WB_HAZARD_EN to enable the pending-write hazard
// comparators; otherwise HAZ1/HAZ2 are tied low.
module regfile_writeback_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    regfile_writeback_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [PW-1:0] mem_slot;
    logic          occupied;
    logic          pop;
    logic          alu_ready;
    logic          mem_ready;
    logic          alu_acc;
    logic          mem_acc;

    assign occupied = (count != '0);
    assign pop      = occupied && !RESET;

    // The head drained this cycle frees its slot for a same-cycle enqueue.
    assign free = CW'(DEPTH) - count + CW'(occupied);

    // Arbitration: MEM wins the last free slot.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!RESET) begin
            if (free >= CW'(2)) begin
                alu_ready = 1'b1;
                mem_ready = 1'b1;
            end else if (free == CW'(1)) begin
                mem_ready = 1'b1;
                alu_ready = !bus.MEM_VALID;
            end
        end
    end

    assign alu_acc  = bus.ALU_VALID && alu_ready;
    assign mem_acc  = bus.MEM_VALID && mem_ready;
    // ALU goes first when both are accepted, so MEM lands one slot later.
    assign mem_slot = wr_ptr + PW'(alu_acc);

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (alu_acc) begin
            addr_q[wr_ptr] <= bus.ALU_ADDR;
            data_q[wr_ptr] <= bus.ALU_DATA;
        end
        if (mem_acc) begin
            addr_q[mem_slot] <= bus.MEM_ADDR;
            data_q[mem_slot] <= bus.MEM_DATA;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(alu_acc) + PW'(mem_acc);
            count  <= count + CW'(alu_acc) + CW'(mem_acc) - CW'(pop);
        end
    end

    // Register file write port, straight from the head entry.
    always_comb begin
        bus.WE3 = pop;
        bus.A3  = '0;
        bus.WD3 = '0;
        if (occupied) begin
            bus.A3  = addr_q[rd_ptr];
            bus.WD3 = data_q[rd_ptr];
        end
    end

    assign bus.ALU_READY = alu_ready;
    assign bus.MEM_READY = mem_ready;
    assign bus.COUNT     = count;

`ifdef WB_HAZARD_EN
    // Match read addresses against every occupied entry, head included.
    always_comb begin
        bus.HAZ1 = 1'b0;
        bus.HAZ2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!RESET && (CW'(i) < count)) begin
                if (addr_q[rd_ptr + PW'(i)] == bus.RA1) begin
                    bus.HAZ1 = 1'b1;
                end
                if (addr_q[rd_ptr + PW'(i)] == bus.RA2) begin
                    bus.HAZ2 = 1'b1;
                end
            end
        end
    end
`else
    logic unused_ra;

    assign bus.HAZ1  = 1'b0;
    assign bus.HAZ2  = 1'b0;
    assign unused_ra = ^{bus.RA1, bus.RA2};
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue (DEPTH=4, AW=5, DW=32).
// Table of per-cycle vectors, then hand-written saturation and reset-flush
// sequences with a small queue model.
module tb_regfile_writeback_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
`ifdef WB_HAZARD_EN
    localparam bit HAZ_ON = 1'b1;
`else
    localparam bit HAZ_ON = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        alu_v;
        logic [4:0]  alu_a;
        logic [31:0] alu_d;
        logic        mem_v;
        logic [4:0]  mem_a;
        logic [31:0] mem_d;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        e_alu_r;
        logic        e_mem_r;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [2:0]  e_cnt;
        logic        e_h1;
        logic        e_h2;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    regfile_writeback_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    regfile_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [4:0] aa,
                         input logic [31:0] ad, input logic mv, input logic [4:0] ma,
                         input logic [31:0] md, input logic [4:0] r1, input logic [4:0] r2);
        rst           = r;
        bus.ALU_VALID = av;
        bus.ALU_ADDR  = aa;
        bus.ALU_DATA  = ad;
        bus.MEM_VALID = mv;
        bus.MEM_ADDR  = ma;
        bus.MEM_DATA  = md;
        bus.RA1       = r1;
        bus.RA2       = r2;
    endtask

    vec_t vecs [17];
    ent_t q [$];

    initial begin
        int   k;
        int   j;
        int   cnt;
        int   free;
        logic exp_ar;
        logic exp_mr;
        ent_t e;

        n_checks = 0;
        n_fail   = 0;

        //          rst av aa  ad            mv ma mdata          ra1 ra2  ar mr we a3 wd            cnt h1 h2
        vecs[0]  = '{1, 1, 9,  32'h99,       0, 0, 32'h0,         31, 31,  0, 0, 0, 0, 32'h0,        0, 0, 0};
        vecs[1]  = '{1, 1, 9,  32'h99,       0, 0, 32'h0,         31, 31,  0, 0, 0, 0, 32'h0,        0, 0, 0};
        vecs[2]  = '{0, 1, 9,  32'h99,       0, 0, 32'h0,         31, 31,  1, 1, 0, 0, 32'h0,        0, 0, 0};
        vecs[3]  = '{0, 0, 0,  32'h0,        0, 0, 32'h0,         31, 31,  1, 1, 1, 9, 32'h99,       1, 0, 0};
        vecs[4]  = '{0, 1, 3,  32'h2A,       0, 0, 32'h0,         31, 31,  1, 1, 0, 0, 32'h0,        0, 0, 0};
        vecs[5]  = '{0, 0, 0,  32'h0,        0, 0, 32'h0,         31, 31,  1, 1, 1, 3, 32'h2A,       1, 0, 0};
        vecs[6]  = '{0, 0, 0,  32'h0,        0, 0, 32'h0,         31, 31,  1, 1, 0, 0, 32'h0,        0, 0, 0};
        vecs[7]  = '{0, 1, 5,  32'h11,       1, 5, 32'h22,        31, 31,  1, 1, 0, 0, 32'h0,        0, 0, 0};
        vecs[8]  = '{0, 0, 0,  32'h0,        0, 0, 32'h0,         31, 31,  1, 1, 1, 5, 32'h11,       2, 0, 0};
        vecs[9]  = '{0, 0, 0,  32'h0,        0, 0, 32'h0,         31, 31,  1, 1, 1, 5, 32'h22,       1, 0, 0};
        vecs[10] = '{0, 0, 0,  32'h0,        0, 0, 32'h0,         31, 31,  1, 1, 0, 0, 32'h0,        0, 0, 0};
        vecs[11] = '{0, 1, 7,  32'h77,       0, 0, 32'h0,          7,  8,  1, 1, 0, 0, 32'h0,        0, 0, 0};
        vecs[12] = '{0, 0, 0,  32'h0,        0, 0, 32'h0,          7,  8,  1, 1, 1, 7, 32'h77,       1, 1, 0};
        vecs[13] = '{0, 0, 0,  32'h0,        0, 0, 32'h0,          7,  8,  1, 1, 0, 0, 32'h0,        0, 0, 0};
        vecs[14] = '{0, 0, 0,  32'h0,        1, 0, 32'hDEADBEEF,   0,  7,  1, 1, 0, 0, 32'h0,        0, 0, 0};
        vecs[15] = '{0, 0, 0,  32'h0,        0, 0, 32'h0,          0,  7,  1, 1, 1, 0, 32'hDEADBEEF, 1, 1, 0};
        vecs[16] = '{0, 0, 0,  32'h0,        0, 0, 32'h0,          0,  7,  1, 1, 0, 0, 32'h0,        0, 0, 0};

        drive(1, 0, 0, 0, 0, 0, 0, 31, 31);
        @(posedge clk);

        // Directed per-cycle vectors: reset hold, single, simultaneous, hazard, r0.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].alu_v, vecs[i].alu_a, vecs[i].alu_d,
                  vecs[i].mem_v, vecs[i].mem_a, vecs[i].mem_d, vecs[i].ra1, vecs[i].ra2);
            #1;
            check("alu_ready", i, 32'(bus.ALU_READY), 32'(vecs[i].e_alu_r));
            check("mem_ready", i, 32'(bus.MEM_READY), 32'(vecs[i].e_mem_r));
            check("we3",       i, 32'(bus.WE3),       32'(vecs[i].e_we));
            check("a3",        i, 32'(bus.A3),        32'(vecs[i].e_a3));
            check("wd3",       i, bus.WD3,            vecs[i].e_wd);
            check("count",     i, 32'(bus.COUNT),     32'(vecs[i].e_cnt));
            check("haz1",      i, 32'(bus.HAZ1),      32'(vecs[i].e_h1 & HAZ_ON));
            check("haz2",      i, 32'(bus.HAZ2),      32'(vecs[i].e_h2 & HAZ_ON));
        end

        // Saturation: both producers valid, then drain; model tracks order.
        k = 0;
        j = 0;
        q.delete();
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic vld;
            vld = (cyc < 12);
            @(negedge clk);
            drive(0, vld, 5'(k), 32'hA000_0000 + 32'(k),
                  vld, 5'(16 + j), 32'hB000_0000 + 32'(j), 31, 31);
            #1;
            cnt    = q.size();
            free   = int'(DEPTH) - cnt + ((cnt > 0) ? 1 : 0);
            exp_mr = (free >= 1);
            exp_ar = (free >= 2) || ((free == 1) && !vld);
            check("sat_alu_ready", cyc, 32'(bus.ALU_READY), 32'(exp_ar));
            check("sat_mem_ready", cyc, 32'(bus.MEM_READY), 32'(exp_mr));
            check("sat_count",     cyc, 32'(bus.COUNT),     32'(cnt));
            check("sat_count_max", cyc, 32'(bus.COUNT <= 3'(DEPTH)), 32'd1);
            check("sat_we3",       cyc, 32'(bus.WE3),       32'(cnt > 0));
            if (cnt > 0) begin
                check("sat_a3",  cyc, 32'(bus.A3), 32'(q[0].a));
                check("sat_wd3", cyc, bus.WD3,     q[0].d);
                void'(q.pop_front());
            end
            if (vld && exp_ar) begin
                e.a = 5'(k);
                e.d = 32'hA000_0000 + 32'(k);
                q.push_back(e);
                k++;
            end
            if (vld && exp_mr) begin
                e.a = 5'(16 + j);
                e.d = 32'hB000_0000 + 32'(j);
                q.push_back(e);
                j++;
            end
        end
        check("sat_drained", 0, 32'(bus.COUNT), 32'd0);

        // Reset flush: fill to three entries, reset, nothing of it is written.
        @(negedge clk);
        drive(0, 1, 1, 32'hF1, 1, 2, 32'hF2, 3, 4);
        #1;
        check("flush_count", 0, 32'(bus.COUNT), 32'd0);
        @(negedge clk);
        drive(0, 1, 3, 32'hF3, 1, 4, 32'hF4, 3, 4);
        #1;
        check("flush_count", 1, 32'(bus.COUNT), 32'd2);
        check("flush_a3",    1, 32'(bus.A3),    32'd1);
        check("flush_wd3",   1, bus.WD3,        32'hF1);
        @(negedge clk);
        drive(1, 1, 9, 32'hF9, 1, 9, 32'hF9, 3, 4);
        #1;
        check("flush_count",     2, 32'(bus.COUNT),     32'd3);
        check("flush_we3",       2, 32'(bus.WE3),       32'd0);
        check("flush_alu_ready", 2, 32'(bus.ALU_READY), 32'd0);
        check("flush_mem_ready", 2, 32'(bus.MEM_READY), 32'd0);
        check("flush_haz1",      2, 32'(bus.HAZ1),      32'd0);
        check("flush_haz2",      2, 32'(bus.HAZ2),      32'd0);
        for (int c = 3; c < 6; c++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 3, 4);
            #1;
            check("flush_we3",   c, 32'(bus.WE3),   32'd0);
            check("flush_count", c, 32'(bus.COUNT), 32'd0);
            check("flush_a3",    c, 32'(bus.A3),    32'd0);
            check("flush_wd3",   c, bus.WD3,        32'd0);
            check("flush_haz1",  c, 32'(bus.HAZ1),  32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
